// File: rtl/block_serializer.sv
// Block serializer: takes a 128-bit block (e.g. AES core output) on a
// valid/ready handshake and emits it as 16 bytes on an AXI-Stream style
// byte interface. Back-to-back blocks stream with no bubble.
//
// Optional feature: define BLOCK_SERIALIZER_TLAST_EN to add the m_axis_tlast
// output, which flags the final byte of each block.
//
// Reset is synchronous and active-low (reset == 0 clears all state).

module block_serializer #(
  // 1: byte 0 is block_data[127:120]; 0: byte 0 is block_data[7:0]
  parameter int unsigned FIRST_BYTE_MSB = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] block_data,
  input  logic         block_valid,
  output logic         block_ready,
  output logic [7:0]   m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready
`ifdef BLOCK_SERIALIZER_TLAST_EN
  ,
  output logic         m_axis_tlast
`endif
);

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   hold_q, hold_d;

  logic           last_byte;
  logic           blk_hs;
  logic           byte_hs;
  logic [3:0]     byte_idx;
  logic [7:0]     sel_byte;

  assign last_byte = (cnt_q == 4'd15);
  assign blk_hs    = block_valid && block_ready;
  assign byte_hs   = m_axis_tvalid && m_axis_tready;

  // Map the byte counter onto a byte lane of the held block.
  always_comb begin
    if (FIRST_BYTE_MSB != 0) begin
      byte_idx = 4'd15 - cnt_q;
    end else begin
      byte_idx = cnt_q;
    end
    sel_byte = hold_q[{byte_idx, 3'b000} +: 8];
  end

  // State, byte counter and holding register; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      hold_q  <= 128'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic: capture on block handshake, advance on byte handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (blk_hs) begin
          hold_d  = block_data;
          cnt_d   = 4'd0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (byte_hs) begin
          if (last_byte) begin
            if (blk_hs) begin
              // Zero-bubble reload: next block starts right after byte 15.
              hold_d  = block_data;
              cnt_d   = 4'd0;
              state_d = StSend;
            end else begin
              cnt_d   = 4'd0;
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs: ready is combinational from reset and m_axis_tready so a new
  // block can be taken on the same edge as the final byte handshake.
  always_comb begin
    block_ready   = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
`ifdef BLOCK_SERIALIZER_TLAST_EN
    m_axis_tlast  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        block_ready = reset;
      end
      StSend: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = sel_byte;
        block_ready   = reset && last_byte && m_axis_tready;
`ifdef BLOCK_SERIALIZER_TLAST_EN
        m_axis_tlast  = last_byte;
`endif
      end
      default: begin
        block_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_block_serializer.sv
// Table-driven bench for block_serializer. Two instances share all inputs:
// one with MSB-first byte order, one with LSB-first. Each vector gives the
// inputs for one cycle and the outputs expected in that same cycle.

module tb_block_serializer;

  logic         clk;
  logic         reset;
  logic [127:0] block_data;
  logic         block_valid;
  logic         m_axis_tready;

  logic         ready_m, ready_l;
  logic [7:0]   tdata_m, tdata_l;
  logic         tvalid_m, tvalid_l;
`ifdef BLOCK_SERIALIZER_TLAST_EN
  logic         tlast_m, tlast_l;
`endif

  block_serializer #(.FIRST_BYTE_MSB(1)) dut_m (
    .clk          (clk),
    .reset        (reset),
    .block_data   (block_data),
    .block_valid  (block_valid),
    .block_ready  (ready_m),
    .m_axis_tdata (tdata_m),
    .m_axis_tvalid(tvalid_m),
    .m_axis_tready(m_axis_tready)
`ifdef BLOCK_SERIALIZER_TLAST_EN
    ,
    .m_axis_tlast (tlast_m)
`endif
  );

  block_serializer #(.FIRST_BYTE_MSB(0)) dut_l (
    .clk          (clk),
    .reset        (reset),
    .block_data   (block_data),
    .block_valid  (block_valid),
    .block_ready  (ready_l),
    .m_axis_tdata (tdata_l),
    .m_axis_tvalid(tvalid_l),
    .m_axis_tready(m_axis_tready)
`ifdef BLOCK_SERIALIZER_TLAST_EN
    ,
    .m_axis_tlast (tlast_l)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [127:0] data;
    logic         valid;
    logic         tready;
    logic         exp_ready;
    logic         exp_tvalid;
    logic [7:0]   exp_m;
    logic [7:0]   exp_l;
    logic         exp_last;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_err;

  localparam logic [127:0] B1   = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] B2   = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] BA   = {16{8'hAA}};
  localparam logic [127:0] BB   = {16{8'h55}};
  localparam logic [127:0] BC   = {16{8'hC3}};
  localparam logic [127:0] JUNK = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

  task automatic add(input logic rst, input logic [127:0] d, input logic v, input logic tr,
                     input logic er, input logic ev, input logic [7:0] em,
                     input logic [7:0] el, input logic et);
    vec_t x;
    x.rst = rst; x.data = d; x.valid = v; x.tready = tr;
    x.exp_ready = er; x.exp_tvalid = ev; x.exp_m = em; x.exp_l = el; x.exp_last = et;
    vecs.push_back(x);
  endtask

  // Idle cycle out of reset: ready high, no output.
  task automatic add_idle();
    add(1'b1, JUNK, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    int pat[4];
    int cnt;
    int p;
    logic tr;

    n_vec = 0;
    n_err = 0;
    pat = '{1, 0, 0, 1};

    // Reset state; block_valid during reset must not be accepted.
    add(1'b0, B1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    add_idle();

    // Single block at full rate: MSB order 00..0F, LSB order 0F..00.
    add(1'b1, B1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++)
      add(1'b1, JUNK, 1'b0, 1'b1, (i == 15), 1'b1, 8'(i), 8'(15 - i), (i == 15));
    add_idle();

    // Backpressure with tready pattern 1,0,0,1; block_data changes after capture.
    add(1'b1, B1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    cnt = 0;
    p = 0;
    while (cnt < 16) begin
      tr = (pat[p % 4] != 0);
      add(1'b1, JUNK, 1'b0, tr, (cnt == 15) && tr, 1'b1, 8'(cnt), 8'(15 - cnt), (cnt == 15));
      if (tr) cnt++;
      p++;
    end
    add_idle();

    // Back-to-back A then B with block_valid held: ready only on A's byte 15.
    add(1'b1, BA, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++)
      add(1'b1, BB, 1'b1, 1'b1, (i == 15), 1'b1, 8'hAA, 8'hAA, (i == 15));
    for (int i = 0; i < 16; i++)
      add(1'b1, JUNK, 1'b0, 1'b1, (i == 15), 1'b1, 8'h55, 8'h55, (i == 15));
    add_idle();

    // Block C offered at byte 5 is refused; taken only at A's byte-15 handshake.
    add(1'b1, BA, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++)
      add(1'b1, BC, (i == 5) || (i == 15), 1'b1, (i == 15), 1'b1, 8'hAA, 8'hAA, (i == 15));
    for (int i = 0; i < 16; i++)
      add(1'b1, JUNK, 1'b0, 1'b1, (i == 15), 1'b1, 8'hC3, 8'hC3, (i == 15));
    add_idle();

    // Reset for one cycle at byte 7; the next block restarts at byte 0.
    add(1'b1, B1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++)
      add(1'b1, JUNK, 1'b0, 1'b1, 1'b0, 1'b1, 8'(i), 8'(15 - i), 1'b0);
    add(1'b0, JUNK, 1'b0, 1'b1, 1'b0, 1'b1, 8'h07, 8'h08, 1'b0);
    add_idle();
    add(1'b1, B2, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++)
      add(1'b1, JUNK, 1'b0, 1'b1, (i == 15), 1'b1, 8'(8'h10 + i), 8'(8'h1F - i), (i == 15));
    add_idle();

    // Initial reset, unchecked (state is unknown before the first edge).
    reset = 1'b0;
    block_data = '0;
    block_valid = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[k]) begin
      @(negedge clk);
      reset         = vecs[k].rst;
      block_data    = vecs[k].data;
      block_valid   = vecs[k].valid;
      m_axis_tready = vecs[k].tready;
      #1;
      n_vec++;
      chk("ready_m",  k, {7'd0, ready_m},  {7'd0, vecs[k].exp_ready});
      chk("ready_l",  k, {7'd0, ready_l},  {7'd0, vecs[k].exp_ready});
      chk("tvalid_m", k, {7'd0, tvalid_m}, {7'd0, vecs[k].exp_tvalid});
      chk("tvalid_l", k, {7'd0, tvalid_l}, {7'd0, vecs[k].exp_tvalid});
      chk("tdata_m",  k, tdata_m, vecs[k].exp_m);
      chk("tdata_l",  k, tdata_l, vecs[k].exp_l);
`ifdef BLOCK_SERIALIZER_TLAST_EN
      chk("tlast_m",  k, {7'd0, tlast_m}, {7'd0, vecs[k].exp_last});
      chk("tlast_l",  k, {7'd0, tlast_l}, {7'd0, vecs[k].exp_last});
`endif
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
